div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative multi-cycle divide/remainder unit executing RV32M DIV, DIVU, REM and REMU.
- Complements the single-cycle ALU: the datapath hands it operands and a start strobe, stalls on Busy, and takes Result on the Done pulse.
- Restoring division, one quotient bit per cycle; sign correction and RISC-V special cases handled internally.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- Start  input  1  request strobe; sampled only in IDLE.
- A  input  WIDTH  dividend.
- B  input  WIDTH  divisor.
- DivOp  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- Result  output  WIDTH  quotient or remainder per the latched DivOp.
- Busy  output  1  high while the operation is in flight (state != IDLE).
- Done  output  1  one-cycle pulse; Result valid from this cycle.
- DivByZero  output  1  set with Done when B was 0; held with Result.

Behaviour:
- Reset (rst high at a clock edge):
  - state IDLE; Result, Done, DivByZero, Busy = 0; counter, remainder and quotient registers cleared.
  - rst overrides everything, including mid-CALC; the in-flight operation is discarded and no Done is produced.
- States: IDLE, CALC, FIX.
- IDLE:
  - On Start=1, latch A, B and DivOp; signed ops (DivOp[0]=0) latch |A|, |B| and record the quotient sign (A[31]^B[31]) and remainder sign (A[31]).
  - If B=0, go to FIX with the special-case flag set.
  - If the op is signed, A=0x80000000 and B=0xFFFFFFFF, go to FIX with the overflow flag set.
  - Otherwise go to CALC, counter=0.
- CALC, one iteration per cycle:
  - Shift {rem, quot} left by 1.
  - If the upper partial remainder >= divisor, subtract and set quot[0]=1.
  - Counter increments; after iteration WIDTH-1 (32nd), go to FIX.
- FIX, one cycle:
  - Select the quotient (DivOp[1]=0) or the remainder (DivOp[1]=1).
  - Signed ops: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set (the remainder takes the dividend's sign).
  - Register Result, pulse Done=1, go to IDLE.
- Special-case results:
  - Divide by zero: quotient = all ones (DIV and DIVU), remainder = A unmodified; DivByZero=1.
  - Signed overflow: quotient = 0x80000000, remainder = 0; DivByZero=0.
- Latency, counting the edge that samples Start as edge 0:
  - Normal operation: Done high after edge 33 (CALC occupies edges 1-32, FIX result at edge 33).
  - Special cases: Done high after edge 1.
- Busy:
  - Goes high after edge 0.
  - Falls in the same cycle that Done is high; the FIX edge returns the state to IDLE.
- Done:
  - High for exactly one cycle.
  - Result and DivByZero hold until the next accepted Start's FIX edge, or until reset.
- Start while Busy is ignored; operands in that cycle are not sampled.
- Start high in the Done cycle is accepted, since the state is IDLE (back-to-back operation).
- Width rules:
  - The partial-remainder register is WIDTH+1 bits so the compare/subtract is carry-safe.
  - All negation is two's complement modulo 2^WIDTH.
  - The counter is clog2(WIDTH) bits.

Decomposition:
- Shared package div_pkg:
  - DivOp encodings: DIVOP_DIV=2'b00, DIVOP_DIVU=2'b01, DIVOP_REM=2'b10, DIVOP_REMU=2'b11.
  - State encoding: IDLE, CALC, FIX.
- One sub-module, div_step: combinational single restoring iteration.
  - Inputs: partial remainder, quotient, divisor.
  - Outputs: next partial remainder, next quotient.
- FSM, counter, sign handling and the output registers stay in div_unit.

Test Plan:
- DIVU A=100, B=7 -> Result=14, Done after edge 33, Busy high for edges 1-32, DivByZero=0; repeat as REMU -> Result=2.
- DIV A=-7 (0xFFFFFFF9), B=2 -> Result=0xFFFFFFFD (-3); REM with the same operands -> Result=0xFFFFFFFF (-1); REM A=7, B=-2 -> Result=1.
- DIVU A=5, B=0 -> Result=0xFFFFFFFF, DivByZero=1, Done after edge 1; REM A=0x80000000, B=0 -> Result=0x80000000.
- DIV A=0x80000000, B=0xFFFFFFFF -> Result=0x80000000, Done after edge 1; REM with the same operands -> Result=0.
- Start with new operands at edge 10 of a DIVU 100/7 -> ignored; Result=14 at edge 33.
  - Start=1 in the Done cycle with DIVU 9/3 -> accepted; Result=3 after 33 further edges.
- rst=1 at edge 15 of a DIVU -> next cycle Busy=0, Done=0, Result=0; no Done pulse follows; a subsequent DIVU 50/5 returns 10.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared encodings for the iterative divide/remainder unit
package div_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] DIVOP_DIV  = 2'b00;
  localparam logic [1:0] DIVOP_DIVU = 2'b01;
  localparam logic [1:0] DIVOP_REM  = 2'b10;
  localparam logic [1:0] DIVOP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_quot,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_quot
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_div_ext;
  logic [WIDTH:0] w_trial;
  logic           w_fits;

  // The partial remainder is always below the divisor, so the shift never loses a set bit.
  assign w_shift   = (i_rem << 1) | {{WIDTH{1'b0}}, i_quot[WIDTH-1]};
  assign w_div_ext = {1'b0, i_div};
  assign w_trial   = w_shift - w_div_ext;
  assign w_fits    = (w_shift >= w_div_ext);

  assign o_rem  = w_fits ? w_trial : w_shift;
  assign o_quot = {i_quot[WIDTH-2:0], w_fits};

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - RV32M DIV/DIVU/REM/REMU iterative unit
// Restoring division, one quotient bit per cycle, with sign fix-up and special cases.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       DivOp,
  output logic [WIDTH-1:0] Result,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic             r_qsign;
  logic             r_rsign;
  logic             r_dz;
  logic [WIDTH-1:0] r_result;
  logic             r_done;
  logic             r_dz_out;

  logic             w_signed;
  logic             w_b_zero;
  logic             w_ovf;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_rem_next;
  logic [WIDTH-1:0] w_quot_next;
  logic [WIDTH-1:0] w_quot_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_signed = ~DivOp[0];
  assign w_abs_a  = (w_signed && A[WIDTH-1]) ? -A : A;
  assign w_abs_b  = (w_signed && B[WIDTH-1]) ? -B : B;
  assign w_b_zero = (B == '0);
  assign w_ovf    = w_signed && (A == MIN_NEG) && (B == '1);

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_quot (r_quot),
    .i_div  (r_div),
    .o_rem  (w_rem_next),
    .o_quot (w_quot_next)
  );

  assign w_quot_fix = r_qsign ? -r_quot : r_quot;
  assign w_rem_fix  = r_rsign ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (Start) w_state_next = (w_b_zero || w_ovf) ? ST_FIX : ST_CALC;
      ST_CALC: if (r_cnt == CNT_W'(WIDTH-1)) w_state_next = ST_FIX;
      ST_FIX:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem    <= '0;
      r_quot   <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_qsign  <= 1'b0;
      r_rsign  <= 1'b0;
      r_dz     <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_dz_out <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (Start) begin
          r_op  <= DivOp;
          r_cnt <= '0;
          r_div <= w_abs_b;
          r_dz  <= w_b_zero;
          // Special cases preload final unsigned values so FIX stays uniform.
          if (w_b_zero) begin
            r_quot  <= '1;
            r_rem   <= {1'b0, A};
            r_qsign <= 1'b0;
            r_rsign <= 1'b0;
          end else if (w_ovf) begin
            r_quot  <= MIN_NEG;
            r_rem   <= '0;
            r_qsign <= 1'b0;
            r_rsign <= 1'b0;
          end else begin
            r_quot  <= w_abs_a;
            r_rem   <= '0;
            r_qsign <= w_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            r_rsign <= w_signed & A[WIDTH-1];
          end
        end
        ST_CALC: begin
          r_rem  <= w_rem_next;
          r_quot <= w_quot_next;
          r_cnt  <= r_cnt + CNT_W'(1);
        end
        ST_FIX: begin
          r_result <= r_op[1] ? w_rem_fix : w_quot_fix;
          r_done   <= 1'b1;
          r_dz_out <= r_dz;
        end
        default: ;
      endcase
    end
  end

  assign Result    = r_result;
  assign Done      = r_done;
  assign DivByZero = r_dz_out;
  assign Busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  DivOp;
  logic [31:0] Result;
  logic        Busy;
  logic        Done;
  logic        DivByZero;

  int total = 0;
  int bad   = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .Start     (Start),
    .A         (A),
    .B         (B),
    .DivOp     (DivOp),
    .Result    (Result),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RISC-V semantics straight from the ISA rules; SV int division truncates toward zero.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       output logic [31:0] res, output logic dz, output int lat);
    logic [31:0] q;
    logic [31:0] r;
    int sa;
    int sb;
    sa  = a;
    sb  = b;
    dz  = 1'b0;
    lat = 33;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1; lat = 1;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; lat = 1;
    end else if (op[0]) begin
      q = a / b; r = a % b;
    end else begin
      q = sa / sb; r = sa % sb;
    end
    res = op[1] ? r : q;
  endtask

  // Counts edges after the Start edge until Done, noting any cycle where Busy dropped early.
  task automatic wait_done(input int start_n, output int n, output int busy_low);
    n = start_n;
    busy_low = 0;
    while (Done !== 1'b1 && n < 100) begin
      if (Busy !== 1'b1) busy_low++;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op);
    logic [31:0] er;
    logic        edz;
    int          lat;
    int          n;
    int          bl;
    model(a, b, op, er, edz, lat);
    @(negedge clk);
    Start = 1'b1; A = a; B = b; DivOp = op;
    @(posedge clk); #1;
    Start = 1'b0; A = $urandom; B = $urandom; DivOp = 2'($urandom_range(0, 3));
    wait_done(0, n, bl);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_res"}, Result, er);
    chk({tag, "_dz"}, 32'(DivByZero), 32'(edz));
    chk({tag, "_busy_inflight"}, bl, 0);
    chk({tag, "_busy_at_done"}, 32'(Busy), 0);
  endtask

  initial begin
    int n;
    int bl;
    int dones;
    logic [31:0] ra;
    logic [31:0] rb;

    rst = 1'b1; Start = 1'b0; A = '0; B = '0; DivOp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", Result, 0);
    chk("reset_done", 32'(Done), 0);
    chk("reset_busy", 32'(Busy), 0);
    chk("reset_dz", 32'(DivByZero), 0);
    rst = 1'b0;

    do_op("divu_100_7", 32'd100, 32'd7, DIVOP_DIVU);
    chk("divu_100_7_const", Result, 32'd14);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(Done), 0);
    chk("result_hold", Result, 32'd14);
    do_op("remu_100_7", 32'd100, 32'd7, DIVOP_REMU);
    chk("remu_100_7_const", Result, 32'd2);
    do_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, DIVOP_DIV);
    chk("div_m7_2_const", Result, 32'hFFFF_FFFD);
    do_op("rem_m7_2", 32'hFFFF_FFF9, 32'd2, DIVOP_REM);
    chk("rem_m7_2_const", Result, 32'hFFFF_FFFF);
    do_op("rem_7_m2", 32'd7, 32'hFFFF_FFFE, DIVOP_REM);
    chk("rem_7_m2_const", Result, 32'd1);
    do_op("divu_by0", 32'd5, 32'd0, DIVOP_DIVU);
    chk("divu_by0_const", Result, 32'hFFFF_FFFF);
    do_op("rem_by0", 32'h8000_0000, 32'd0, DIVOP_REM);
    chk("rem_by0_const", Result, 32'h8000_0000);
    do_op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, DIVOP_DIV);
    chk("div_ovf_const", Result, 32'h8000_0000);
    chk("div_ovf_nodz", 32'(DivByZero), 0);
    do_op("rem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, DIVOP_REM);
    chk("rem_ovf_const", Result, 32'd0);
    do_op("divu_big", 32'h8000_0000, 32'hFFFF_FFFF, DIVOP_DIVU);
    do_op("div_neg_neg", 32'hFFFF_FF9C, 32'hFFFF_FFF9, DIVOP_DIV);

    // Start while busy must be ignored.
    @(negedge clk);
    Start = 1'b1; A = 32'd100; B = 32'd7; DivOp = DIVOP_DIVU;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    Start = 1'b1; A = 32'd1000; B = 32'd3; DivOp = DIVOP_DIV;
    @(posedge clk); #1;
    Start = 1'b0;
    wait_done(10, n, bl);
    chk("ignore_lat", n, 33);
    chk("ignore_res", Result, 32'd14);

    // Back-to-back start in the Done cycle.
    Start = 1'b1; A = 32'd9; B = 32'd3; DivOp = DIVOP_DIVU;
    @(posedge clk); #1;
    Start = 1'b0;
    chk("b2b_busy", 32'(Busy), 1);
    chk("b2b_hold", Result, 32'd14);
    wait_done(0, n, bl);
    chk("b2b_lat", n, 33);
    chk("b2b_res", Result, 32'd3);
    chk("b2b_busy_inflight", bl, 0);

    // Reset mid-CALC discards the operation.
    @(negedge clk);
    Start = 1'b1; A = 32'd123456; B = 32'd7; DivOp = DIVOP_DIVU;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_result", Result, 0);
    chk("rst_dz", 32'(DivByZero), 0);
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (Done === 1'b1) dones++;
    end
    chk("rst_no_done", dones, 0);
    do_op("after_rst", 32'd50, 32'd5, DIVOP_DIVU);
    chk("after_rst_const", Result, 32'd10);

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if (i == 3) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      do_op($sformatf("rand%0d", i), ra, rb, 2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
